// File: rtl/param_sequence_detector.sv
// Runtime-programmable serial pattern detector with overlap control and a saturating match counter.
// Optional macro SEQ_DET_MASK_EN adds a per-bit don't-care mask loaded alongside the pattern.
module param_sequence_detector #(
    parameter int                   PATTERN_W       = 8,
    parameter int                   LEN_W           = 4,
    parameter int                   CNT_W           = 8,
    parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = PATTERN_W'(8'b0000_1011),
    parameter int                   DEFAULT_LEN     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in,
    input  logic                 data_valid,
    input  logic                 pattern_load,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic [LEN_W-1:0]     pattern_len,
`ifdef SEQ_DET_MASK_EN
    input  logic [PATTERN_W-1:0] pattern_mask_in,
`endif
    input  logic                 overlap_en,
    input  logic                 count_clear,
    output logic                 detect,
    output logic [CNT_W-1:0]     match_count,
    output logic                 count_sat
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN     = LEN_W'(PATTERN_W);
    localparam logic [CNT_W-1:0] CNT_ALMOST  = {{(CNT_W-1){1'b1}}, 1'b0};

    logic [PATTERN_W-1:0] history_r;
    logic [PATTERN_W-1:0] pattern_r;
    logic [PATTERN_W-1:0] care_s;
    logic [LEN_W-1:0]     fill_r;
    logic [LEN_W-1:0]     len_r;
    logic [LEN_W-1:0]     len_load_s;
    logic [PATTERN_W-1:0] history_next_s;
    logic [LEN_W-1:0]     fill_next_s;
    logic                 shift_s;
    logic                 match_s;
    logic                 detect_r;
    logic [CNT_W-1:0]     count_r;
    logic                 sat_r;
    state_t               state_r;

    // Masked compare of the low len history bits against the pattern.
    function automatic logic pattern_hit(input logic [PATTERN_W-1:0] hist,
                                         input logic [PATTERN_W-1:0] pat,
                                         input logic [PATTERN_W-1:0] care,
                                         input logic [LEN_W-1:0]     len);
        logic [PATTERN_W-1:0] diff;
        diff = (hist ^ pat) & care;
        for (int i = 0; i < PATTERN_W; i++) begin
            if (i >= int'(len)) begin
                diff[i] = 1'b0;
            end
        end
        return (diff == {PATTERN_W{1'b0}});
    endfunction

    function automatic state_t state_of(input logic [LEN_W-1:0] fill,
                                        input logic [LEN_W-1:0] len);
        if (fill == {LEN_W{1'b0}}) begin
            return IDLE;
        end else if (fill >= len) begin
            return ARMED;
        end else begin
            return FILLING;
        end
    endfunction

`ifdef SEQ_DET_MASK_EN
    logic [PATTERN_W-1:0] mask_r;
    assign care_s = mask_r;
`else
    assign care_s = {PATTERN_W{1'b1}};
`endif

    // A load wins over the bit in the same cycle, so the bit neither shifts nor matches.
    assign shift_s    = data_valid & ~pattern_load;
    assign len_load_s = ((pattern_len == {LEN_W{1'b0}}) || (pattern_len > MAX_LEN)) ? MAX_LEN : pattern_len;

    // Next history/fill and the match decision for the current bit.
    always_comb begin
        history_next_s = history_r;
        fill_next_s    = fill_r;
        if (shift_s) begin
            history_next_s = {history_r[PATTERN_W-2:0], data_in};
            if (fill_r < MAX_LEN) begin
                fill_next_s = fill_r + LEN_W'(1);
            end else begin
                fill_next_s = fill_r;
            end
        end else begin
            fill_next_s = fill_r;
        end
        match_s = shift_s && ((state_r == ARMED) || (fill_next_s >= len_r)) &&
                  pattern_hit(history_next_s, pattern_r, care_s, len_r);
    end

    // Control FSM with history, pattern registers, detect pulse and saturating counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            history_r <= {PATTERN_W{1'b0}};
            fill_r    <= {LEN_W{1'b0}};
            pattern_r <= DEFAULT_PATTERN;
            len_r     <= LEN_W'(DEFAULT_LEN);
`ifdef SEQ_DET_MASK_EN
            mask_r    <= {PATTERN_W{1'b1}};
`endif
            state_r   <= IDLE;
            detect_r  <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
            sat_r     <= 1'b0;
        end else begin
            detect_r <= match_s;
            if (count_clear) begin
                count_r <= {CNT_W{1'b0}};
                sat_r   <= 1'b0;
            end else if (match_s && !sat_r) begin
                count_r <= count_r + CNT_W'(1);
                sat_r   <= (count_r == CNT_ALMOST);
            end else begin
                count_r <= count_r;
                sat_r   <= sat_r;
            end

            if (pattern_load) begin
                pattern_r <= pattern_in;
                len_r     <= len_load_s;
`ifdef SEQ_DET_MASK_EN
                mask_r    <= pattern_mask_in;
`endif
                fill_r    <= {LEN_W{1'b0}};
                state_r   <= IDLE;
            end else begin
                history_r <= history_next_s;
                if (match_s && !overlap_en) begin
                    fill_r  <= {LEN_W{1'b0}};
                    state_r <= IDLE;
                end else begin
                    fill_r <= fill_next_s;
                    case (state_r)
                        IDLE:    state_r <= state_of(fill_next_s, len_r);
                        FILLING: state_r <= state_of(fill_next_s, len_r);
                        ARMED:   state_r <= ARMED;
                        default: state_r <= IDLE;
                    endcase
                end
            end
        end
    end

    assign detect      = detect_r;
    assign match_count = count_r;
    assign count_sat   = sat_r;

endmodule

// File: doc/param_sequence_detector.md
Name: param_sequence_detector

Overview:
- Runtime-programmable serial bit-pattern detector; parametrised successor to the fixed 1011 detector.
- Pattern value and length (1..PATTERN_W) are loadable; overlapping or non-overlapping match mode is selectable.
- Sits on a serial bit stream with a valid qualifier; outputs a registered one-cycle detect pulse and a saturating match counter.

Parameters:
- PATTERN_W, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of pattern_len; must hold PATTERN_W.
- CNT_W, 8, width of match_count.
- DEFAULT_PATTERN, 8'b0000_1011, pattern value after reset (LSB-aligned).
- DEFAULT_LEN, 4, pattern length after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- data_in  input  1  serial data bit.
- data_valid  input  1  data_in is sampled only when 1.
- pattern_load  input  1  loads pattern_in/pattern_len this cycle.
- pattern_in  input  PATTERN_W  new pattern, LSB-aligned.
- pattern_len  input  LEN_W  new pattern length.
- overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping.
- count_clear  input  1  synchronous clear of match_count.
- detect  output  1  one-cycle pulse per match.
- match_count  output  CNT_W  saturating number of matches.
- count_sat  output  1  match_count is all ones.

Behaviour:
- Reset (rst=0, asynchronous): history=0, fill=0, pattern=DEFAULT_PATTERN, len=DEFAULT_LEN, detect=0, match_count=0, count_sat=0.
- History: PATTERN_W-bit shift register. On a valid bit: history <= {history[PATTERN_W-2:0], data_in}, and fill (count of bits held) increments, saturating at PATTERN_W.
- Bit order: the first-received bit of a match compares to pattern[len-1]; the last-received bit compares to pattern[0]. Example: 4'b1011 means stream 1,0,1,1.
- Match condition: valid bit this cycle, fill_next >= len, and the low len bits of history_next equal pattern[len-1:0].
- detect: registered and asserted in the cycle after the completing bit's clock edge, for exactly one cycle. Latency is 1 cycle.
- Overlap mode (overlap_en=1): history and fill are untouched by a match.
- Non-overlap mode (overlap_en=0): on a match, fill <= 0, so the next match needs len fresh bits.
- overlap_en is sampled on every valid bit and may change at any time.
- data_valid=0: no shift and no match; detect=0 the next cycle.
- pattern_load: pattern and len update on the edge; history is kept and fill <= 0.
  - Load has priority over data_valid in the same cycle: that bit is discarded and no match is evaluated.
  - pattern_len=0 or pattern_len>PATTERN_W is stored as PATTERN_W.
  - Unused pattern bits above len are ignored.
- match_count: increments on every match and saturates at 2^CNT_W-1.
  - count_sat = (match_count == all ones), registered alongside the count.
  - count_clear sets the count to 0 and takes priority over a simultaneous match (result 0).
  - count_clear does not affect history, fill or detect.
- Control: a single FSM with states IDLE (fill=0), FILLING (0<fill<len) and ARMED (fill>=len).
  - Transitions follow fill.
  - A match in non-overlap mode goes to IDLE.
  - A pattern load goes to IDLE.

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- Defined: adds input pattern_mask_in [PATTERN_W-1:0], loaded with pattern_load; reset value is all ones.
  - A history bit whose mask bit is 0 is a don't-care in the compare.
  - Length, fill and mode rules are unchanged.
- Undefined: no port; every bit below len is compared exactly.

Test Plan:
- Reset defaults, overlap_en=1, stream 1,0,1,1,0,1,1 (valid every cycle) -> detect pulses after bits 4 and 7; match_count=2.
- Same stream with overlap_en=0 -> detect only after bit 4; match_count=1.
- Load pattern_in=8'b0110_0101, pattern_len=7 while data_valid=1 that cycle, then stream 1,1,0,0,1,0,1 -> the loading-cycle bit is discarded; one detect after bit 7.
- Stream 1,0,x,1,1 with data_valid=0 on the x cycle (x=0) -> one detect after the last bit; detect=0 during the gap.
- CNT_W=2, overlap_en=1, repeated 1011 stream giving 5 matches -> match_count sticks at 3 with count_sat=1. Then count_clear coinciding with a match -> match_count=0.
- Assert rst mid-pattern after bits 1,0,1, then send a single 1 -> no detect; all outputs 0 immediately on rst falling (asynchronous).
